ysyx_220066_memwr_arb: RTL and testbench
========================================

Name: ysyx_220066_memwr_arb

Overview:
- Store-side arbiter and write queue in front of the data-memory write port.
- Accepts store requests from two requesters: req0 is the LSU store path; req1 is a secondary master such as a debug or DMA writer.
- Arbitration is round-robin. The block checks alignment, derives the byte write mask from MemOp and addr[2:0], and buffers stores in a DEPTH-entry FIFO.
- It presents one store per cycle to the downstream memory writer over a valid/ready handshake.

Parameters:
- DEPTH, 4, FIFO entries. Must be a power of 2, at least 2.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has a store.
- req0_ready  out  1  requester 0 store accepted this cycle.
- req0_addr  in  64  requester 0 byte address.
- req0_data  in  64  requester 0 store data, lane-aligned by the requester.
- req0_memop  in  3  requester 0 size code.
- req1_valid, req1_ready, req1_addr, req1_data, req1_memop: same as req0, for requester 1.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  downstream writer consumes the head.
- out_addr  out  64  head address.
- out_data  out  64  head data, passed unmodified.
- out_wmask  out  8  head byte mask.
- empty  out  1  FIFO holds no entries; used by fence logic.
- misalign  out  1  one-cycle pulse: a misaligned store was dropped.
- misalign_src  out  1  requester index of the dropped store; valid when misalign=1.

Behaviour:
- Reset (rst=0, asynchronous):
  - count, read pointer and write pointer go to 0.
  - out_valid=0, empty=1, misalign=0, misalign_src=0.
  - The round-robin pointer is set so that req0 wins the first conflict.
  - Asserting reset mid-operation discards all queued stores immediately; out_valid falls without waiting for a clock.
- MemOp encoding:
  - 000: byte. Mask bit addr[2:0] set.
  - 001: half. Mask bits {2k, 2k+1} set, with k=addr[2:1].
  - 010: word. Mask 8'h0F if addr[2]=0, else 8'hF0.
  - Any other code: doubleword, mask 8'hFF.
- Alignment check:
  - Half is misaligned if addr[0]=1.
  - Word is misaligned if addr[1:0]!=0.
  - Doubleword is misaligned if addr[2:0]!=0.
  - Byte is never misaligned.
- Arbitration:
  - At most one request is granted per cycle.
  - Only one requester valid: that requester is granted.
  - Both valid: grant the requester not granted on the most recent grant.
  - The round-robin pointer updates only on an actual handshake (valid and ready).
- Ready:
  - reqN_ready = granted and (count<DEPTH, or a pop occurs this cycle).
  - Ready may depend combinationally on the other requester's valid. It must not depend on the requester's own ready.
- Pop: out_valid and out_ready. The read pointer advances and count decrements.
- Push: handshake on an aligned request. Stores {addr, data, wmask}; the write pointer advances and count increments.
- Simultaneous push and pop, including when full: count is unchanged and both pointers advance.
- Misaligned handshake:
  - The request is accepted (ready=1), so the requester is not stalled.
  - Nothing is enqueued.
  - The next cycle shows misalign=1 and misalign_src set to the granted index.
  - The round-robin pointer still updates.
- Latency:
  - A store accepted at edge N gives out_valid=1 after edge N, i.e. in the cycle following acceptance.
  - There is no combinational path from request to output.
- Output stability: out_addr, out_data and out_wmask hold stable while out_valid=1 and out_ready=0.
- Pointers wrap modulo DEPTH. Count ranges 0..DEPTH.
- empty = (count==0), registered-state derived. out_valid = !empty.
- Ordering: stores leave in grant order.

Test Plan:
- Reset then one req0 store: addr=0x80000003, memop=000, data=0xAB<<24, out_ready=1.
  → out_valid rises one cycle after the handshake, with out_wmask=8'h08 and out_addr=0x80000003; empty returns to 1 after the pop.
- Both requesters valid every cycle, out_ready=1.
  → grants alternate 0,1,0,1, req0 first; out_addr sequence interleaves in the same order.
- out_ready=0 while DEPTH=4 stores are pushed.
  → the 5th request sees ready=0 and out_addr stays on the first entry.
  → Then raise out_ready and drive a 5th request in the same cycle: push and pop occur, count stays 4, and the FIFO wraps correctly.
- req1 word store at addr=0x...6.
  → accepted with ready=1; misalign=1 and misalign_src=1 for one cycle; no entry enqueued; empty stays 1.
- Masks with memop=001 at addr[2:0]=4 → 8'h30; memop=010 at addr=4 → 8'hF0; memop=011 at addr=0 → 8'hFF.
- Assert rst low mid-burst with 3 entries queued.
  → out_valid=0 and empty=1 immediately; after release, the first conflict grants req0.

Source files
------------

// File: rtl/ysyx_220066_memwr_arb.sv
// ysyx_220066_memwr_arb
// Store-side arbiter and write queue in front of the data-memory write port.
// Two requesters (req0 = LSU stores, req1 = debug/DMA writer) are arbitrated
// round-robin. The granted store is alignment-checked, given a byte mask
// derived from its MemOp and addr[2:0], and queued in a DEPTH-entry FIFO whose
// head is offered to the downstream writer over a valid/ready handshake.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   reqN_valid/ready         requester N handshake
//   reqN_addr/data/memop     requester N byte address, lane-aligned data, size code
//   out_valid/ready          FIFO head handshake to the memory writer
//   out_addr/data/wmask      FIFO head contents
//   empty                    FIFO holds no entries
//   misalign, misalign_src   one-cycle pulse and requester index of a dropped store
module ysyx_220066_memwr_arb #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [63:0] req0_addr,
    input  logic [63:0] req0_data,
    input  logic [2:0]  req0_memop,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [63:0] req1_addr,
    input  logic [63:0] req1_data,
    input  logic [2:0]  req1_memop,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_addr,
    output logic [63:0] out_data,
    output logic [7:0]  out_wmask,
    output logic        empty,
    output logic        misalign,
    output logic        misalign_src
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [CW-1:0] r_count;
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic          r_rr_last;
    logic          r_misalign;
    logic          r_misalign_src;

    logic [63:0]   r_q_addr [DEPTH];
    logic [63:0]   r_q_data [DEPTH];
    logic [7:0]    r_q_mask [DEPTH];

    logic          w_any;
    logic          w_gnt_idx;
    logic          w_pop;
    logic          w_space;
    logic          w_hs;
    logic          w_push;
    logic          w_mis;
    logic [63:0]   w_sel_addr;
    logic [63:0]   w_sel_data;
    logic [2:0]    w_sel_memop;
    logic [7:0]    w_mask;

    // On a conflict the requester that did not win the last handshake goes first.
    assign w_any     = req0_valid | req1_valid;
    assign w_gnt_idx = (req0_valid && req1_valid) ? ~r_rr_last : req1_valid;

    assign w_pop   = out_valid & out_ready;
    // A pop in the same cycle frees a slot, so a full queue can still accept.
    assign w_space = (r_count < DEPTH_C) | w_pop;

    assign req0_ready = w_any & ~w_gnt_idx & w_space;
    assign req1_ready = w_any &  w_gnt_idx & w_space;

    assign w_sel_addr  = w_gnt_idx ? req1_addr  : req0_addr;
    assign w_sel_data  = w_gnt_idx ? req1_data  : req0_data;
    assign w_sel_memop = w_gnt_idx ? req1_memop : req0_memop;

    assign w_hs   = w_any & w_space;
    assign w_push = w_hs & ~w_mis;

    always_comb begin
        w_mask = 8'hFF;
        w_mis  = 1'b0;
        case (w_sel_memop)
            3'b000: begin
                w_mask = 8'h01 << w_sel_addr[2:0];
                w_mis  = 1'b0;
            end
            3'b001: begin
                w_mask = 8'h03 << {w_sel_addr[2:1], 1'b0};
                w_mis  = w_sel_addr[0];
            end
            3'b010: begin
                w_mask = w_sel_addr[2] ? 8'hF0 : 8'h0F;
                w_mis  = |w_sel_addr[1:0];
            end
            default: begin
                w_mask = 8'hFF;
                w_mis  = |w_sel_addr[2:0];
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count        <= '0;
            r_rd_ptr       <= '0;
            r_wr_ptr       <= '0;
            r_rr_last      <= 1'b1;
            r_misalign     <= 1'b0;
            r_misalign_src <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_hs) r_rr_last <= w_gnt_idx;
            r_misalign <= w_hs & w_mis;
            if (w_hs & w_mis) r_misalign_src <= w_gnt_idx;
        end
    end

    // Storage needs no reset: entries are only visible through r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_addr[r_wr_ptr] <= w_sel_addr;
            r_q_data[r_wr_ptr] <= w_sel_data;
            r_q_mask[r_wr_ptr] <= w_mask;
        end
    end

    assign empty        = (r_count == '0);
    assign out_valid    = ~empty;
    assign out_addr     = r_q_addr[r_rd_ptr];
    assign out_data     = r_q_data[r_rd_ptr];
    assign out_wmask    = r_q_mask[r_rd_ptr];
    assign misalign     = r_misalign;
    assign misalign_src = r_misalign_src;

endmodule

// File: tb/tb_ysyx_220066_memwr_arb.sv
module tb_ysyx_220066_memwr_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready;
    logic [63:0] req0_addr, req0_data;
    logic [2:0]  req0_memop;
    logic        req1_valid, req1_ready;
    logic [63:0] req1_addr, req1_data;
    logic [2:0]  req1_memop;
    logic        out_valid, out_ready;
    logic [63:0] out_addr, out_data;
    logic [7:0]  out_wmask;
    logic        empty, misalign, misalign_src;

    always #5 clk = ~clk;

    ysyx_220066_memwr_arb #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
        .req0_data(req0_data), .req0_memop(req0_memop),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
        .req1_data(req1_data), .req1_memop(req1_memop),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_data(out_data), .out_wmask(out_wmask),
        .empty(empty), .misalign(misalign), .misalign_src(misalign_src)
    );

    typedef struct packed {
        logic [63:0] addr;
        logic [63:0] data;
        logic [7:0]  mask;
    } ent_t;

    ent_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  p_mask0, p_mask1;
    logic        p_mis0, p_mis1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic half();
        @(negedge clk);
    endtask

    // Called at a negedge: checks the head against the scoreboard, records
    // accepted stores, then advances past the next posedge.
    task automatic step();
        ent_t e;
        chk("out_valid_vs_sb", out_valid, 64'(sb.size() != 0));
        if (out_valid && out_ready && sb.size() != 0) begin
            e = sb.pop_front();
            chk("pop_addr", out_addr, e.addr);
            chk("pop_data", out_data, e.data);
            chk("pop_mask", out_wmask, e.mask);
        end
        if (req0_valid && req0_ready && !p_mis0) sb.push_back({req0_addr, req0_data, p_mask0});
        if (req1_valid && req1_ready && !p_mis1) sb.push_back({req1_addr, req1_data, p_mask1});
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic [63:0] a, input logic [63:0] d, input logic [2:0] op,
                          input logic [7:0] m, input logic mis);
        req0_valid = 1'b1; req0_addr = a; req0_data = d; req0_memop = op;
        p_mask0 = m; p_mis0 = mis;
    endtask

    task automatic drive1(input logic [63:0] a, input logic [63:0] d, input logic [2:0] op,
                          input logic [7:0] m, input logic mis);
        req1_valid = 1'b1; req1_addr = a; req1_data = d; req1_memop = op;
        p_mask1 = m; p_mis1 = mis;
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && sb.size() != 0; k++) begin
            half();
            step();
        end
        chk("drain_done", 64'(sb.size()), 64'd0);
    endtask

    task automatic do_reset();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b0;
        sb.delete();
        #2;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_misalign", misalign, 1'b0);
        chk("rst_misalign_src", misalign_src, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    logic [7:0]  m5  [5];
    logic [2:0]  op5 [5];
    logic [63:0] a5  [5];

    initial begin
        int n0, n1;
        rst = 1'b0;
        out_ready = 1'b0;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0; req0_memop = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0; req1_memop = '0;
        p_mask0 = '0; p_mask1 = '0; p_mis0 = 1'b0; p_mis1 = 1'b0;
        do_reset();

        // single byte store from req0
        out_ready = 1'b1;
        drive0(64'h8000_0003, 64'h0000_0000_AB00_0000, 3'b000, 8'h08, 1'b0);
        half();
        chk("t1_ready0", req0_ready, 1'b1);
        chk("t1_empty_before", empty, 1'b1);
        step();
        req0_valid = 1'b0;
        half();
        chk("t1_valid_next", out_valid, 1'b1);
        chk("t1_wmask", out_wmask, 8'h08);
        chk("t1_addr", out_addr, 64'h8000_0003);
        step();
        half();
        chk("t1_empty_after", empty, 1'b1);
        step();

        // both requesters every cycle: alternating grants, req0 first
        do_reset();
        out_ready = 1'b1;
        n0 = 0; n1 = 0;
        for (int i = 0; i < 4; i++) begin
            drive0(64'h1000 + 64'(8 * n0), 64'h1111_0000 + 64'(n0), 3'b011, 8'hFF, 1'b0);
            drive1(64'h2000 + 64'(8 * n1), 64'h2222_0000 + 64'(n1), 3'b011, 8'hFF, 1'b0);
            half();
            chk("t2_gnt0", req0_ready, 64'(i % 2 == 0));
            chk("t2_gnt1", req1_ready, 64'(i % 2 == 1));
            step();
            if (i % 2 == 0) n0++; else n1++;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain();

        // fill to DEPTH, back-pressure, push+pop while full, wrap
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive0(64'h3000 + 64'(8 * k), 64'hC0DE_0000 + 64'(k), 3'b011, 8'hFF, 1'b0);
            half();
            chk("t3_fill_ready", req0_ready, 1'b1);
            step();
        end
        drive0(64'h3020, 64'hC0DE_0004, 3'b011, 8'hFF, 1'b0);
        half();
        chk("t3_full_ready", req0_ready, 1'b0);
        chk("t3_head_hold", out_addr, 64'h3000);
        step();
        out_ready = 1'b1;
        half();
        chk("t3_pushpop_ready", req0_ready, 1'b1);
        chk("t3_head_still", out_addr, 64'h3000);
        step();
        out_ready = 1'b0;
        drive0(64'h3028, 64'hC0DE_0005, 3'b011, 8'hFF, 1'b0);
        half();
        chk("t3_still_full", req0_ready, 1'b0);
        chk("t3_head_next", out_addr, 64'h3008);
        step();
        req0_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        // misaligned word store from req1
        drive1(64'h8000_0006, 64'h5555_5555_0000_0000, 3'b010, 8'hF0, 1'b1);
        half();
        chk("t4_ready1", req1_ready, 1'b1);
        step();
        req1_valid = 1'b0;
        half();
        chk("t4_misalign", misalign, 1'b1);
        chk("t4_misalign_src", misalign_src, 1'b1);
        chk("t4_empty", empty, 1'b1);
        step();
        half();
        chk("t4_misalign_pulse", misalign, 1'b0);
        step();

        // mask derivation
        a5[0] = 64'h4004; op5[0] = 3'b001; m5[0] = 8'h30;
        a5[1] = 64'h4004; op5[1] = 3'b010; m5[1] = 8'hF0;
        a5[2] = 64'h4000; op5[2] = 3'b011; m5[2] = 8'hFF;
        a5[3] = 64'h4005; op5[3] = 3'b000; m5[3] = 8'h20;
        a5[4] = 64'h4006; op5[4] = 3'b001; m5[4] = 8'hC0;
        for (int k = 0; k < 5; k++) begin
            drive0(a5[k], 64'h7700 + 64'(k), op5[k], m5[k], 1'b0);
            half();
            chk("t5_ready", req0_ready, 1'b1);
            step();
        end
        req0_valid = 1'b0;
        drain();

        // async reset with 3 entries queued
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive0(64'h5000 + 64'(8 * k), 64'h9900 + 64'(k), 3'b011, 8'hFF, 1'b0);
            half();
            step();
        end
        req0_valid = 1'b0;
        half();
        chk("t6_queued", out_valid, 1'b1);
        #1;
        rst = 1'b0;
        #1;
        chk("t6_rst_out_valid", out_valid, 1'b0);
        chk("t6_rst_empty", empty, 1'b1);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        out_ready = 1'b1;
        drive0(64'h6000, 64'hAAAA, 3'b011, 8'hFF, 1'b0);
        drive1(64'h6100, 64'hBBBB, 3'b011, 8'hFF, 1'b0);
        half();
        chk("t6_first_gnt0", req0_ready, 1'b1);
        chk("t6_first_gnt1", req1_ready, 1'b0);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
